// File: rtl/counter_pkg.sv
// counter_pkg: state encoding and defaults shared by the counter family
package counter_pkg;
  localparam int DEF_WIDTH = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/down_count_timer_if.sv
// down_count_timer_if: command and status bundle of the down-count timer
interface down_count_timer_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;
  logic             done;
  modport master (
    output load, load_val, start, stop, en, auto_reload,
    input  Q, busy, tc, done
  );
  modport slave (
    input  load, load_val, start, stop, en, auto_reload,
    output Q, busy, tc, done
  );
endinterface

// File: rtl/down_count_core.sv
// down_count_core: count register with load/decrement mux and terminal compares
module down_count_core
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic             is_one,
  output logic             is_zero
);
  always_ff @(posedge clk or negedge clear)
    if (!clear) q <= '0;
    else        q <= ld ? ld_val : dec ? q - WIDTH'(1) : q;
  assign is_one  = q == WIDTH'(1);
  assign is_zero = q == '0;
endmodule

// File: rtl/down_count_timer.sv
// down_count_timer: loadable down counter with one-shot and auto-reload terminal count
module down_count_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               clear,
  down_count_timer_if.slave bus
);
  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;
  logic             is_one;
  logic             is_zero;
  logic             stop_run;
  logic             can_start;
  logic             restart;
  logic             run_ok;
  logic             term;
  logic             ld;
  logic             dec;
  logic [WIDTH-1:0] ld_val;
  // stop only matters in RUN, so it can never collide with a restart
  assign stop_run  = !bus.load && bus.stop && state == RUN;
  assign can_start = (state == IDLE && (!is_zero || reload != '0)) ||
                     (state == DONE && reload != '0);
  assign restart   = !bus.load && bus.start && can_start;
  assign run_ok    = !bus.load && !bus.stop && bus.en && state == RUN;
  assign term      = run_ok && is_one;
  assign dec       = run_ok && !is_one;
  // Q is zero in DONE, so restarting with Q==0 covers both IDLE and DONE reloads
  assign ld        = bus.load || term || (restart && is_zero);
  assign ld_val    = bus.load ? bus.load_val : (term && !bus.auto_reload) ? '0 : reload;
  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clear  (clear),
    .ld     (ld),
    .dec    (dec),
    .ld_val (ld_val),
    .q      (q),
    .is_one (is_one),
    .is_zero(is_zero)
  );
  always_ff @(posedge clk or negedge clear)
    if (!clear) begin
      state  <= IDLE;
      reload <= '0;
      busy   <= 1'b0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else if (bus.load) begin
      state  <= IDLE;
      reload <= bus.load_val;
      busy   <= 1'b0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      tc <= term;
      if (stop_run) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (restart) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else if (term && !bus.auto_reload) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  assign bus.Q    = q;
  assign bus.busy = busy;
  assign bus.tc   = tc;
  assign bus.done = done;
endmodule

// File: tb/tb_down_count_timer.sv
// tb_down_count_timer: directed vector table plus reset corner sequence
module tb_down_count_timer;
  typedef struct packed {
    logic       ld;
    logic [3:0] lv;
    logic       st;
    logic       sp;
    logic       en;
    logic       ar;
    logic [3:0] q;
    logic       b;
    logic       t;
    logic       d;
  } vec_t;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  down_count_timer_if #(.WIDTH(4)) bus ();
  down_count_timer #(.WIDTH(4)) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus)
  );
  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask
  task automatic drive(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                       input logic en, input logic ar);
    bus.load = ld;
    bus.load_val = lv;
    bus.start = st;
    bus.stop = sp;
    bus.en = en;
    bus.auto_reload = ar;
  endtask
  task automatic check_all(input string nm, input int idx, input logic [3:0] q, input logic b,
                           input logic t, input logic d);
    chk({nm, ".Q"}, idx, bus.Q, q);
    chk({nm, ".busy"}, idx, {3'b0, bus.busy}, {3'b0, b});
    chk({nm, ".tc"}, idx, {3'b0, bus.tc}, {3'b0, t});
    chk({nm, ".done"}, idx, {3'b0, bus.done}, {3'b0, d});
  endtask
  task automatic step(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                      input logic en, input logic ar);
    @(negedge clk);
    drive(ld, lv, st, sp, en, ar);
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                     input logic en, input logic ar, input logic [3:0] q, input logic b,
                     input logic t, input logic d);
    tv.push_back({ld, lv, st, sp, en, ar, q, b, t, d});
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_all("reset", 0, 4'd0, 0, 0, 0);
    @(negedge clk) clear = 1'b1;
    step(1, 4'd5, 0, 0, 0, 0);
    check_all("rst_seq", 1, 4'd5, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    check_all("rst_seq", 2, 4'd5, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_all("rst_seq", 3, 4'd3, 1, 0, 0);
    #2 clear = 1'b0;
    #1;
    check_all("midreset", 4, 4'd0, 0, 0, 0);
    @(negedge clk) clear = 1'b1;
    // one-shot of 3, restart from DONE, load beating start, stop at Q==1
    add(1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0, 0);
    add(0, 0,    1, 0, 1, 0, 4'd3, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd2, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd1, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd0, 0, 1, 1);
    add(0, 0,    0, 0, 1, 0, 4'd0, 0, 0, 1);
    add(0, 0,    1, 0, 0, 0, 4'd3, 1, 0, 0);
    add(1, 4'd2, 1, 0, 1, 0, 4'd2, 0, 0, 0);
    add(0, 0,    1, 0, 0, 0, 4'd2, 1, 0, 0);
    add(0, 0,    0, 0, 0, 0, 4'd2, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd1, 1, 0, 0);
    add(0, 0,    0, 1, 1, 0, 4'd1, 0, 0, 0);
    add(0, 0,    1, 0, 0, 0, 4'd1, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd0, 0, 1, 1);
    // auto-reload period 4
    add(1, 4'd4, 0, 0, 0, 1, 4'd4, 0, 0, 0);
    add(0, 0,    1, 0, 1, 1, 4'd4, 1, 0, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 0, 0, 0, 1, 1, (k % 4 == 0) ? 4'd4 : 4'(4 - k % 4), 1, k % 4 == 0, 0);
    // reload of 1 ticks on every strobe
    add(1, 4'd1, 0, 0, 0, 1, 4'd1, 0, 0, 0);
    add(0, 0,    1, 0, 0, 1, 4'd1, 1, 0, 0);
    add(0, 0,    0, 0, 1, 1, 4'd1, 1, 1, 0);
    add(0, 0,    0, 0, 1, 1, 4'd1, 1, 1, 0);
    add(0, 0,    0, 0, 0, 1, 4'd1, 1, 0, 0);
    // prescaled count, pause, resume from held value
    add(1, 4'd6, 0, 0, 0, 0, 4'd6, 0, 0, 0);
    add(0, 0,    1, 0, 0, 0, 4'd6, 1, 0, 0);
    add(0, 0,    0, 0, 0, 0, 4'd6, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd5, 1, 0, 0);
    add(0, 0,    0, 0, 0, 0, 4'd5, 1, 0, 0);
    add(0, 0,    0, 0, 0, 0, 4'd5, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd4, 1, 0, 0);
    add(0, 0,    0, 1, 1, 0, 4'd4, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 4'd4, 0, 0, 0);
    add(0, 0,    1, 0, 0, 0, 4'd4, 1, 0, 0);
    add(0, 0,    0, 0, 1, 0, 4'd3, 1, 0, 0);
    // zero reload cannot start
    add(1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0);
    add(0, 0,    1, 0, 1, 0, 4'd0, 0, 0, 0);
    // full-range countdown without underflow
    add(1, 4'hF, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    add(0, 0,    1, 0, 1, 0, 4'hF, 1, 0, 0);
    for (int k = 1; k <= 15; k++) add(0, 0, 0, 0, 1, 0, 4'(15 - k), k < 15, k == 15, k == 15);
    add(0, 0,    0, 0, 1, 0, 4'd0, 0, 0, 1);
    foreach (tv[i]) begin
      step(tv[i].ld, tv[i].lv, tv[i].st, tv[i].sp, tv[i].en, tv[i].ar);
      check_all("vec", i, tv[i].q, tv[i].b, tv[i].t, tv[i].d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
Synchronous, loadable down counter and terminal-count timer. It is the complement of the team's ripple up counter: it counts down from a programmed value to zero instead of up from zero. It is used as a programmable delay (one-shot) or as a divide-by-N tick generator (auto-reload). All state is in one clock domain; only the reset is asynchronous.

Parameters:
WIDTH, 4, counter and reload-value width in bits (must be >= 2)

Ports:
clk  input  1  single clock; all non-reset state changes on posedge
clear  input  1  asynchronous active-low reset
load  input  1  load reload register and Q from load_val
load_val  input  WIDTH  value captured on load
start  input  1  begin or resume counting
stop  input  1  pause counting, Q holds
en  input  1  count enable (prescale strobe); decrement only when high
auto_reload  input  1  1 = periodic mode, 0 = one-shot
Q  output  WIDTH  current count
busy  output  1  high while state is RUN
tc  output  1  one-cycle terminal-count pulse (registered)
done  output  1  sticky one-shot completion flag

Behaviour:
- Reset (clear low, asynchronous): Q=0, reload_reg=0, state=IDLE, busy=0, tc=0, done=0. Reset takes effect immediately, even mid-count. Exit is on the first posedge with clear high.
- States: IDLE, RUN, DONE. busy = (state==RUN), and is registered.
- Per-cycle command priority: load > stop > start > count.
- load, in any state: reload_reg<=load_val, Q<=load_val, state->IDLE, done<=0, tc<=0.
- stop: in RUN, state->IDLE and Q holds. In IDLE or DONE, no effect.
- start in IDLE:
  - Q!=0: resume, state->RUN, Q unchanged.
  - Q==0 and reload_reg!=0: Q<=reload_reg, state->RUN.
  - Both zero: ignored.
- start in DONE: Q<=reload_reg, done<=0, state->RUN (ignored if reload_reg==0). start in RUN is ignored.
- RUN with en=0: Q holds, tc=0.
- RUN with en=1 and Q>1: Q<=Q-1.
- RUN with en=1 and Q==1, the terminal event. tc<=1 for exactly one cycle. auto_reload is sampled at this edge:
  - auto_reload=1: Q<=reload_reg, stay in RUN. Period = reload_reg en-strobes. With reload_reg==1, tc is asserted on every en strobe.
  - auto_reload=0: Q<=0, state->DONE, done<=1.
- tc is low in all other cycles, including the cycles when load or stop win over a terminal event.
- Simultaneous stop and terminal event: stop wins. Q holds at 1 and no tc is generated.
- Wrap-around: Q never decrements below 0. Q==0 is never seen in RUN.
- done stays set until load or start-from-DONE. It is unaffected by en.
- Latency: command to output change is one posedge. There is no combinational path from inputs to outputs.
- Width rules: all arithmetic is unsigned, modulo-WIDTH-free (no borrow out). load_val is taken verbatim.

Decomposition:
- Shared package/include counter_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH
- Reuse the same state encoding in any future up/down counter blocks.
- One natural sub-module: down_count_core. It holds the WIDTH-bit Q register, the decrement and reload mux, and an is_one compare.
- down_count_timer keeps the FSM, the reload_reg, and the tc/done flags.

Test Plan:
- Reset and mid-count reset: release clear, load 4'd5, start; pull clear low while Q=3 -> Q=0, busy=0, done=0 immediately, with no clock needed.
- One-shot: load 4'd3, start, en=1 continuously -> Q sequence 3,2,1,0; tc high exactly one cycle, coincident with Q=0; done=1, busy=0, state DONE.
- Auto-reload: load 4'd4, auto_reload=1, start, en=1 for 12 cycles -> Q 4,3,2,1,4,3,2,1,4,...; tc pulses every 4 cycles, three times; done stays 0.
- Prescale and pause: load 4'd6, start, en high every 3rd cycle, then stop at Q=4 for 5 cycles -> Q steps only on en, holds at 4 while paused; start resumes from 4, not 6.
- Priority and corners:
  - load and start in the same cycle -> load wins, state IDLE, Q=load_val.
  - stop at Q=1 with en=1 -> Q stays 1, tc=0.
  - start with reload_reg=0 -> ignored, busy=0.
- Restart from DONE: after a one-shot of 4'd2, assert start -> done clears, Q=2, busy=1; load 4'hF, start -> counts 15 down to 0 with no underflow.
